// File: rtl/flash_loader.sv
// flash_loader: boot-time image loader. Receives a length-prefixed,
// little-endian word image over 8N1 UART and writes each word to the
// flash port at consecutive addresses, holding the CPU until complete.
module flash_loader #(
  parameter int WIDTH        = 32,
  parameter int CLKS_PER_BIT = 434,
  parameter int BASE_ADDR    = 0,
  parameter int MAX_WORDS    = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_rx,
  output logic             flash_en,
  output logic [WIDTH-1:0] flash_addr,
  output logic [WIDTH-1:0] flash_data,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IDXW = $clog2(MAX_WORDS + 1);

  localparam logic [CW-1:0]    HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]    FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [WIDTH-1:0] BASE_W  = WIDTH'(BASE_ADDR);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  localparam logic [2:0] L_HDR   = 3'd0;
  localparam logic [2:0] L_DATA  = 3'd1;
  localparam logic [2:0] L_WRITE = 3'd2;
  localparam logic [2:0] L_DONE  = 3'd3;
  localparam logic [2:0] L_ERR   = 3'd4;

  logic            rx_m, rx_s;
  logic [1:0]      rstate;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      rx_byte;
  logic            byte_valid;
  logic            frame_err;

  logic [2:0]      lstate;
  logic [1:0]      byte_idx;
  logic [23:0]     word_sr;
  logic [31:0]     word;
  logic [IDXW-1:0] widx;
  logic [IDXW-1:0] nwords;

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= uart_rx;
      rx_s <= rx_m;
    end
  end

  // UART receiver: mid-bit sampling, start-bit glitch rejection, stop check
  always_ff @(posedge clk) begin
    if (rst) begin
      rstate     <= R_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rstate)
        R_IDLE: begin
          cnt <= '0;
          if (!rx_s) rstate <= R_START;
        end
        R_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_cnt <= '0;
            rstate  <= rx_s ? R_IDLE : R_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            rx_byte <= {rx_s, rx_byte[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) rstate <= R_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          // Back to idle on the sample edge so an immediate start bit is seen
          if (cnt == FULL_M1) begin
            cnt    <= '0;
            rstate <= R_IDLE;
            if (rx_s) byte_valid <= 1'b1;
            else      frame_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Completed little-endian word: top byte is the one arriving now
  assign word = {rx_byte, word_sr};

  // Loader: header count, word assembly, one-cycle write strobe per word
  always_ff @(posedge clk) begin
    if (rst) begin
      lstate     <= L_HDR;
      byte_idx   <= '0;
      word_sr    <= '0;
      widx       <= '0;
      nwords     <= '0;
      flash_en   <= 1'b0;
      flash_addr <= BASE_W;
      flash_data <= '0;
    end else begin
      flash_en <= 1'b0;
      case (lstate)
        L_HDR, L_DATA: begin
          if (frame_err) begin
            lstate <= L_ERR;
          end else if (byte_valid) begin
            byte_idx <= byte_idx + 1'b1;
            case (byte_idx)
              2'd0: word_sr[7:0]   <= rx_byte;
              2'd1: word_sr[15:8]  <= rx_byte;
              2'd2: word_sr[23:16] <= rx_byte;
              default: begin
                if (lstate == L_HDR) begin
                  if (word == 32'd0 || word > 32'(MAX_WORDS)) begin
                    lstate <= L_ERR;
                  end else begin
                    nwords <= word[IDXW-1:0];
                    widx   <= '0;
                    lstate <= L_DATA;
                  end
                end else begin
                  flash_en   <= 1'b1;
                  flash_addr <= BASE_W + (WIDTH'(widx) << 2);
                  flash_data <= WIDTH'(word);
                  lstate     <= L_WRITE;
                end
              end
            endcase
          end
        end
        L_WRITE: begin
          widx   <= widx + IDXW'(1);
          lstate <= ((widx + IDXW'(1)) == nwords) ? L_DONE : L_DATA;
        end
        default: ; // L_DONE / L_ERR are terminal until reset
      endcase
    end
  end

  // Status outputs decoded from the loader state
  always_comb begin
    done     = (lstate == L_DONE);
    error    = (lstate == L_ERR);
    cpu_hold = (lstate != L_DONE);
  end

endmodule

// File: tb/tb_flash_loader.sv
// tb_flash_loader: directed scenarios for flash_loader with a fast UART.
module tb_flash_loader;

  localparam int CPB  = 4;
  localparam int BASE = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic        flash_en;
  logic [31:0] flash_addr;
  logic [31:0] flash_data;
  logic        cpu_hold, done, error;

  int checks = 0;
  int failures = 0;

  logic [31:0] wr_addr [16];
  logic [31:0] wr_data [16];
  int          wr_cnt  = 0;
  int          en_long = 0;
  logic        en_prev = 1'b0;

  flash_loader #(.WIDTH(32), .CLKS_PER_BIT(CPB), .BASE_ADDR(BASE), .MAX_WORDS(4)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .flash_en(flash_en), .flash_addr(flash_addr), .flash_data(flash_data),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Record every write strobe and flag any strobe longer than one cycle
  always @(negedge clk) begin
    en_prev <= flash_en;
    if (flash_en === 1'b1) begin
      wr_addr[wr_cnt[3:0]] <= flash_addr;
      wr_data[wr_cnt[3:0]] <= flash_data;
      wr_cnt <= wr_cnt + 1;
      if (en_prev === 1'b1) en_long <= en_long + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    uart_rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns at the negedge where flash_en is high, or ok=0 on timeout
  task automatic wait_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (flash_en === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_err(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (error === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    checks++;
    if ({flash_en, cpu_hold, done, error} !== 4'b0100) begin
      failures++;
      $display("FAIL reset_ctrl en/hold/done/err got %b want 0100", {flash_en, cpu_hold, done, error});
    end
    checks++;
    if (flash_addr !== 32'h100 || flash_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus addr=%h data=%h want 00000100/00000000", flash_addr, flash_data);
    end
  endtask

  task automatic test_two_words;
    int base;
    bit ok;
    do_reset();
    base = wr_cnt;
    send_word(32'd2);
    send_word(32'hDEADBEEF);
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    wait_en(ok);
    checks++;
    if (!ok || flash_addr !== 32'h104 || flash_data !== 32'h13 || done !== 1'b0) begin
      failures++;
      $display("FAIL two_words_last ok=%0d addr=%h data=%h done=%b want 1/00000104/00000013/0", ok, flash_addr, flash_data, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0 || flash_en !== 1'b0) begin
      failures++;
      $display("FAIL two_words_done done=%b hold=%b err=%b en=%b want 1/0/0/0", done, cpu_hold, error, flash_en);
    end
    checks++;
    if (flash_addr !== 32'h104 || flash_data !== 32'h13) begin
      failures++;
      $display("FAIL two_words_hold addr=%h data=%h want 00000104/00000013", flash_addr, flash_data);
    end
    // Bytes after completion must be ignored
    send_word(32'hA5A5A5A5);
    idle(10);
    checks++;
    if (wr_cnt - base !== 2 || wr_addr[base[3:0]] !== 32'h100 || wr_data[base[3:0]] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL two_words_first n=%0d addr=%h data=%h want 2/00000100/deadbeef", wr_cnt - base, wr_addr[base[3:0]], wr_data[base[3:0]]);
    end
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      failures++;
      $display("FAIL two_words_after done=%b err=%b want 1/0", done, error);
    end
  endtask

  task automatic test_count_zero;
    int base;
    bit ok;
    do_reset();
    base = wr_cnt;
    send_word(32'd0);
    wait_err(ok);
    idle(10);
    checks++;
    if (!ok || wr_cnt !== base || cpu_hold !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL count_zero err_seen=%0d writes=%0d hold=%b done=%b want 1/0/1/0", ok, wr_cnt - base, cpu_hold, done);
    end
  endtask

  task automatic test_count_over;
    int base;
    bit ok;
    do_reset();
    base = wr_cnt;
    send_word(32'd5);
    wait_err(ok);
    checks++;
    if (!ok || wr_cnt !== base) begin
      failures++;
      $display("FAIL count_over err_seen=%0d writes=%0d want 1/0", ok, wr_cnt - base);
    end
    do_reset();
    checks++;
    if (error !== 1'b0 || cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL count_over_rst err=%b hold=%b want 0/1", error, cpu_hold);
    end
    send_word(32'd1);
    send_word(32'h12345678);
    wait_en(ok);
    checks++;
    if (!ok || flash_addr !== 32'h100 || flash_data !== 32'h12345678) begin
      failures++;
      $display("FAIL count_over_load ok=%0d addr=%h data=%h want 1/00000100/12345678", ok, flash_addr, flash_data);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL count_over_done done=%b hold=%b want 1/0", done, cpu_hold);
    end
  endtask

  task automatic test_framing;
    int base;
    bit ok;
    do_reset();
    base = wr_cnt;
    send_word(32'd1);
    send_byte(8'h55, 1'b0);
    wait_err(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL framing_err error=%b want 1", error);
    end
    idle(12);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1);
    idle(20);
    checks++;
    if (error !== 1'b1 || wr_cnt !== base || cpu_hold !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL framing_hold err=%b writes=%0d hold=%b done=%b want 1/0/1/0", error, wr_cnt - base, cpu_hold, done);
    end
  endtask

  task automatic test_glitch;
    bit ok;
    do_reset();
    @(negedge clk);
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    idle(20);
    checks++;
    if (error !== 1'b0 || done !== 1'b0 || cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL glitch_idle err=%b done=%b hold=%b want 0/0/1", error, done, cpu_hold);
    end
    // A spurious byte would misalign the header and corrupt this load
    send_word(32'd1);
    send_word(32'hA1B2C3D4);
    wait_en(ok);
    checks++;
    if (!ok || flash_addr !== 32'h100 || flash_data !== 32'hA1B2C3D4) begin
      failures++;
      $display("FAIL glitch_load ok=%0d addr=%h data=%h want 1/00000100/a1b2c3d4", ok, flash_addr, flash_data);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      failures++;
      $display("FAIL glitch_done done=%b err=%b want 1/0", done, error);
    end
  endtask

  task automatic test_reset_mid;
    int base;
    bit ok;
    do_reset();
    base = wr_cnt;
    send_word(32'd3);
    send_word(32'h0BADCAFE);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    idle(10);
    checks++;
    if (wr_cnt - base !== 1 || flash_data !== 32'h0BADCAFE) begin
      failures++;
      $display("FAIL mid_pre writes=%0d data=%h want 1/0badcafe", wr_cnt - base, flash_data);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({flash_en, cpu_hold, done, error} !== 4'b0100 || flash_addr !== 32'h100 || flash_data !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset ctrl=%b addr=%h data=%h want 0100/00000100/00000000", {flash_en, cpu_hold, done, error}, flash_addr, flash_data);
    end
    rst = 1'b0;
    idle(2);
    send_word(32'd1);
    send_word(32'hCAFEF00D);
    wait_en(ok);
    checks++;
    if (!ok || flash_addr !== 32'h100 || flash_data !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL mid_reload ok=%0d addr=%h data=%h want 1/00000100/cafef00d", ok, flash_addr, flash_data);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL mid_done done=%b hold=%b want 1/0", done, cpu_hold);
    end
  endtask

  task automatic test_strobe_width;
    checks++;
    if (en_long !== 0) begin
      failures++;
      $display("FAIL strobe_width long_strobes=%0d want 0", en_long);
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_count_zero();
    test_count_over();
    test_framing();
    test_glitch();
    test_reset_mid();
    test_strobe_width();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flash_loader.md
# flash_loader

Boot-time program loader driving the datapath's flash write port (flash_en, flash_addr, flash_data). Receives a length-prefixed program image over an 8N1 UART line, assembles little-endian 32-bit words, and writes each into memory with a single-cycle flash_en strobe at consecutive word addresses. Holds the CPU in reset (cpu_hold) until the image is fully written, then releases it. Fatal protocol errors latch until reset.

## Interface
- WIDTH, 32: data/address width of the flash port.
- CLKS_PER_BIT, 434: clk cycles per UART bit. 434 gives 115200 baud at 50 MHz. Must be ≥ 4.
- BASE_ADDR, 0: byte address of the first image word.
- MAX_WORDS, 1024: largest accepted word count.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- uart_rx  in  1  asynchronous serial input; idles high.
- flash_en  out  1  one-cycle write strobe to memory.
- flash_addr  out  WIDTH  byte address of the write; valid while flash_en=1.
- flash_data  out  WIDTH  word to write; valid while flash_en=1.
- cpu_hold  out  1  high while loading; the top level ORs it into the CPU reset.
- done  out  1  image fully written; sticky until rst.
- error  out  1  protocol error; sticky until rst.

## Operation
- **Input synchronizer:** uart_rx passes through a 2-flop synchronizer (rx_s). The synchronizer resets to 1.
- **UART RX FSM:** R_IDLE → R_START → R_DATA → R_STOP.
  - R_IDLE: rx_s=0 starts a bit counter.
  - R_START: at CLKS_PER_BIT/2 (integer division), rx_s is resampled. If it is 1, treat as a glitch and return to R_IDLE with no byte and no error. If it is 0, go to R_DATA.
  - R_DATA: 8 samples, each CLKS_PER_BIT apart, shifted in LSB first.
  - R_STOP: one sample CLKS_PER_BIT later. Stop=1 raises byte_valid for one cycle. Stop=0 is a framing error.
  - Both outcomes return to R_IDLE the next cycle.
- **Word assembly:** a 2-bit byte index places byte k at bits [8k+7:8k], little-endian. Byte index 3 completes a word.
- **Loader FSM:**
  - L_HDR: collects the 4-byte word count N. On completion: N=0 or N>MAX_WORDS → L_ERR; otherwise → L_DATA with word index = 0.
  - L_DATA: collects data words. On completion → L_WRITE.
  - L_WRITE: one cycle. flash_en=1, flash_addr=BASE_ADDR+4·index, flash_data=assembled word. Then index increments. If the new index equals N → L_DONE, else → L_DATA.
  - L_DONE: done=1, cpu_hold=0. All further UART bytes are ignored.
  - L_ERR: error=1, cpu_hold=1, flash_en=0 permanently. Only rst exits.
- **Framing errors:** a framing error in L_HDR or L_DATA → L_ERR. Framing errors in L_DONE are ignored.
- **Address arithmetic:** computed in WIDTH bits and wraps modulo 2^WIDTH. The word index is a counter of width $clog2(MAX_WORDS+1).

## Timing
- **Reset values:** flash_en=0, flash_addr=BASE_ADDR, flash_data=0, cpu_hold=1, done=0, error=0. Both FSMs return to their idle/L_HDR states. Byte index, word index and shift registers are cleared.
- **Reset mid-operation:** any partial header or word is discarded and loading restarts at L_HDR. Memory already written is not erased.
- **Byte latency:** byte_valid asserts CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the synchronized start edge, plus 2 synchronizer cycles.
- **Write latency:**
  - flash_en asserts exactly 1 cycle after byte_valid of the 4th byte of a data word and lasts exactly 1 cycle.
  - flash_addr and flash_data hold their values after the strobe until the next write.
  - The minimum spacing between strobes is 4 byte times, so memory needs no backpressure.
- **Last word:** done=1 and cpu_hold=0 on the cycle after the final flash_en strobe.
- **Back-to-back bytes:** a start bit immediately following a stop sample must be caught; R_IDLE is entered the same cycle byte_valid pulses.

## Test plan
Bench uses CLKS_PER_BIT=4, BASE_ADDR=0x100, MAX_WORDS=4.
1. Send count 2, then words 0xDEADBEEF and 0x00000013, byte order EF BE AD DE 13 00 00 00 → two flash_en pulses: (0x100, 0xDEADBEEF) then (0x104, 0x00000013). done=1 and cpu_hold=0 on the cycle after the second pulse; error=0.
2. Send count 0 → error=1 after the 4th header byte. No flash_en ever. cpu_hold stays 1.
3. Send count 5 (>MAX_WORDS) → error=1, no writes. Assert rst, then send a valid 1-word image 0x12345678 → write at 0x100, done=1.
4. Send count 1 and the first byte of the word with its stop bit driven 0 → error=1, no flash_en, and error holds through 3 further valid bytes.
5. Drive a 1-cycle low glitch on uart_rx while idle → no byte_valid, no error, loader state unchanged. A following valid 1-word image completes normally.
6. Assert rst mid-way through the 2nd word of a 3-word load → all outputs return to reset values next cycle. A fresh 1-word load writes at 0x100.
